// File: rtl/bp_me_bedrock_reg_timer.sv
// rtl/bp_me_bedrock_reg_timer.sv - machine timer register bank (mtime, mtimecmp, ctrl, W1C status); option macro BP_ME_REG_TIMER_PRESCALE_EN
module bp_me_bedrock_reg_timer
  #(parameter int els_p            = 4
   ,parameter int reg_width_p      = 64
   ,parameter int paddr_width_p    = 40
   ,parameter int reg_addr_width_p = paddr_width_p
   ,localparam int lg_reg_width_lp = 2
   )
  (input  logic                                 clk_i
  ,input  logic                                 reset_n_i
  ,input  logic [els_p-1:0]                     r_v_i
  ,input  logic [els_p-1:0]                     w_v_i
  ,input  logic [reg_addr_width_p-1:0]          addr_i
  ,input  logic [lg_reg_width_lp-1:0]           size_i
  ,input  logic [reg_width_p-1:0]               data_i
  ,output logic [els_p-1:0][reg_width_p-1:0]    data_o
  ,output logic                                 timer_irq_o
  );

`ifdef BP_ME_REG_TIMER_PRESCALE_EN
  localparam logic [reg_width_p-1:0] ctrl_mask_lp = 64'h0000_0000_0000_FF03;
`else
  localparam logic [reg_width_p-1:0] ctrl_mask_lp = 64'h0000_0000_0000_0003;
`endif

  logic [reg_width_p-1:0] mtime_r, mtimecmp_r, ctrl_r;
  logic                   pending_r, irq_r;

  logic [2:0]             offset;
  logic [7:0]             byte_mask;
  logic [reg_width_p-1:0] bit_mask, wdata_shifted;
  logic [reg_width_p-1:0] mtime_merged, mtimecmp_merged, ctrl_merged;
  logic                   status_clr, hit, tick, count_en, irq_en;
  logic [els_p-1:0][reg_width_p-1:0] reg_view;

  assign count_en = ctrl_r[0];
  assign irq_en   = ctrl_r[1];
  assign hit      = (mtime_r >= mtimecmp_r);

  // Byte-lane mask and lane-aligned write data; misaligned offsets are aligned down to the access size
  always_comb begin
    offset    = 3'b000;
    byte_mask = 8'h00;
    bit_mask  = '0;
    unique case (size_i)
      2'd0:    begin offset = addr_i[2:0];             byte_mask = 8'h01; end
      2'd1:    begin offset = {addr_i[2:1], 1'b0};     byte_mask = 8'h03; end
      2'd2:    begin offset = {addr_i[2], 2'b00};      byte_mask = 8'h0F; end
      default: begin offset = 3'b000;                  byte_mask = 8'hFF; end
    endcase
    byte_mask = byte_mask << offset;
    for (int b = 0; b < 8; b++) begin
      bit_mask[b*8 +: 8] = {8{byte_mask[b]}};
    end
    wdata_shifted = data_i << {offset, 3'b000};
  end

  assign mtime_merged    = (mtime_r    & ~bit_mask) | (wdata_shifted & bit_mask);
  assign mtimecmp_merged = (mtimecmp_r & ~bit_mask) | (wdata_shifted & bit_mask);
  assign ctrl_merged     = ((ctrl_r    & ~bit_mask) | (wdata_shifted & bit_mask)) & ctrl_mask_lp;
  assign status_clr      = w_v_i[3] & bit_mask[0] & wdata_shifted[0];

  // Read views of every register as seen before this cycle's update
  always_comb begin
    reg_view    = '0;
    reg_view[0] = mtime_r;
    reg_view[1] = mtimecmp_r;
    reg_view[2] = ctrl_r;
    reg_view[3] = {{(reg_width_p-1){1'b0}}, pending_r};
  end

`ifdef BP_ME_REG_TIMER_PRESCALE_EN
  logic [7:0] pscnt_r;
  assign tick = (pscnt_r == ctrl_r[15:8]);

  // Prescale counter: 0..prescale while counting, restarted by any ctrl write
  always_ff @(posedge clk_i) begin
    if (!reset_n_i || w_v_i[2])
      pscnt_r <= 8'd0;
    else if (count_en)
      pscnt_r <= tick ? 8'd0 : pscnt_r + 8'd1;
  end
`else
  assign tick = 1'b1;
`endif

  // mtime: a write takes precedence over the increment in the same cycle
  always_ff @(posedge clk_i) begin
    if (!reset_n_i)
      mtime_r <= '0;
    else if (w_v_i[0])
      mtime_r <= mtime_merged;
    else if (count_en && tick)
      mtime_r <= mtime_r + 64'd1;
  end

  // mtimecmp, ctrl and sticky pending; a compare hit overrides a concurrent clear
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      mtimecmp_r <= '1;
      ctrl_r     <= '0;
      pending_r  <= 1'b0;
      irq_r      <= 1'b0;
    end else begin
      if (w_v_i[1]) mtimecmp_r <= mtimecmp_merged;
      if (w_v_i[2]) ctrl_r     <= ctrl_merged;
      pending_r <= hit | (pending_r & ~status_clr);
      irq_r     <= pending_r & irq_en;
    end
  end

  // Read data latches the pre-update value and holds until the next read of that register
  always_ff @(posedge clk_i) begin
    if (!reset_n_i)
      data_o <= '0;
    else
      for (int i = 0; i < els_p; i++)
        if (r_v_i[i]) data_o[i] <= reg_view[i];
  end

  assign timer_irq_o = irq_r;

  a_r_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i) $onehot0(r_v_i));
  a_w_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i) $onehot0(w_v_i));

endmodule

// File: tb/tb_bp_me_bedrock_reg_timer.sv
// tb/tb_bp_me_bedrock_reg_timer.sv - self-checking bench for bp_me_bedrock_reg_timer
module tb_bp_me_bedrock_reg_timer;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [3:0]        r_v = '0;
  logic [3:0]        w_v = '0;
  logic [39:0]       addr = '0;
  logic [1:0]        size = '0;
  logic [63:0]       data = '0;
  logic [3:0][63:0]  data_o;
  logic              irq;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

`ifdef BP_ME_REG_TIMER_PRESCALE_EN
  localparam logic [63:0] CTRL_MASK = 64'hFF03;
`else
  localparam logic [63:0] CTRL_MASK = 64'h0003;
`endif

  bp_me_bedrock_reg_timer dut
    (.clk_i(clk), .reset_n_i(reset_n), .r_v_i(r_v), .w_v_i(w_v), .addr_i(addr)
    ,.size_i(size), .data_i(data), .data_o(data_o), .timer_irq_o(irq));

  always #5 clk = ~clk;

  // Reference model state
  logic [63:0] m_mtime, m_cmp, m_ctrl;
  bit          m_pend, m_irq;
  logic [63:0] m_data [4];
  logic [7:0]  m_pcnt;

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [39:0] a,
                                        input logic [1:0] sz, input logic [63:0] d);
    int n = 1 << sz;
    int off = (int'(a[2:0]) / n) * n;
    logic [63:0] r = old;
    for (int b = 0; b < n; b++) r[(off+b)*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: one step of the register bank per rising edge
  always @(posedge clk) begin : model
    logic [63:0] o_mtime, o_cmp, o_ctrl;
    bit o_pend, hit, tick, clr;
    int n;
    if (!reset_n) begin
      m_mtime = 0; m_cmp = '1; m_ctrl = 0; m_pend = 0; m_irq = 0; m_pcnt = 0;
      for (int i = 0; i < 4; i++) m_data[i] = 0;
    end else begin
      o_mtime = m_mtime; o_cmp = m_cmp; o_ctrl = m_ctrl; o_pend = m_pend;
      if (r_v[0]) m_data[0] = o_mtime;
      if (r_v[1]) m_data[1] = o_cmp;
      if (r_v[2]) m_data[2] = o_ctrl;
      if (r_v[3]) m_data[3] = {63'd0, o_pend};
      hit = o_mtime >= o_cmp;
`ifdef BP_ME_REG_TIMER_PRESCALE_EN
      tick = (m_pcnt == o_ctrl[15:8]);
      if (w_v[2]) m_pcnt = 0;
      else if (o_ctrl[0]) m_pcnt = tick ? 8'd0 : m_pcnt + 8'd1;
`else
      tick = 1;
`endif
      if (w_v[0]) m_mtime = merge(o_mtime, addr, size, data);
      else if (o_ctrl[0] && tick) m_mtime = o_mtime + 1;
      if (w_v[1]) m_cmp = merge(o_cmp, addr, size, data);
      if (w_v[2]) m_ctrl = merge(o_ctrl, addr, size, data) & CTRL_MASK;
      n = 1 << size;
      clr = w_v[3] && ((int'(addr[2:0]) / n) * n == 0) && data[0];
      m_pend = hit || (o_pend && !clr);
      m_irq = o_pend && o_ctrl[1];
    end
  end

  // Compare DUT outputs with the model every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 4; i++) check($sformatf("data_o[%0d]", i), data_o[i], m_data[i]);
      check("timer_irq_o", {63'd0, irq}, {63'd0, m_irq});
    end
  end

  task automatic drive(input logic [3:0] r, input logic [3:0] w, input logic [39:0] a,
                       input logic [1:0] s, input logic [63:0] d);
    r_v = r; w_v = w; addr = a; size = s; data = d;
    @(posedge clk); #1;
    r_v = 0; w_v = 0; addr = 0; size = 0; data = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rd(input int i);
    drive(4'b1 << i, 4'b0, 40'd0, 2'd0, 64'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [63:0] a, b, exp, rnd;
    int n, wi;
    logic [3:0] r, w;

    reset_n = 0;
    idle(2);
    reset_n = 1;
    chk_en = 1;
    check("reset irq", {63'd0, irq}, 64'd0);
    check("reset data_o[0]", data_o[0], 64'd0);
    check("reset data_o[1]", data_o[1], 64'd0);

    // Reset and count
    drive(0, 4'b0100, 0, 3, 64'h3);
    idle(9);
    rd(0);
    check("count mtime", data_o[0], 64'd9);
    check("count irq", {63'd0, irq}, 64'd0);

    // Compare and interrupt
    drive(0, 4'b0010, 0, 3, 64'd20);
    n = 0;
    while (!irq && n < 50) begin idle(1); n++; end
    check("irq rise latency", n, 11);
    drive(0, 4'b1000, 0, 3, 64'd1);
    rd(3);
    check("pending held by hit", data_o[3], 64'd1);
    drive(0, 4'b0010, 0, 3, '1);
    drive(0, 4'b1000, 0, 3, 64'd1);
    check("irq one cycle after clear", {63'd0, irq}, 64'd1);
    idle(1);
    check("irq cleared", {63'd0, irq}, 64'd0);

    // Partial writes
    drive(0, 4'b0010, 0, 3, 64'h1122334455667788);
    drive(0, 4'b0010, 40'h5, 2, 64'hAABBCCDD);
    rd(1);
    check("partial word", data_o[1], 64'hAABBCCDD55667788);
    drive(0, 4'b0010, 40'h1, 0, 64'hEE);
    rd(1);
    check("partial byte", data_o[1], 64'hAABBCCDD5566EE88);

    // Wrap
    drive(0, 4'b0001, 0, 3, 64'hFFFF_FFFF_FFFF_FFFE);
    idle(2);
    rd(0);
    check("wrap", data_o[0], 64'd0);

    // Prescale / ctrl field masking
    drive(0, 4'b0100, 0, 3, 64'h0301);
    rd(0);
    a = data_o[0];
    idle(7);
    rd(0);
    b = data_o[0];
`ifdef BP_ME_REG_TIMER_PRESCALE_EN
    check("prescale rate", b - a, 64'd2);
    rd(2);
    check("ctrl read", data_o[2], 64'h0301);
`else
    check("no prescale rate", b - a, 64'd8);
    rd(2);
    check("ctrl read", data_o[2], 64'h0001);
`endif

    // Read latch
    exp = m_mtime;
    rd(0);
    for (int k = 0; k < 5; k++) begin
      check("read latch hold", data_o[0], exp);
      idle(1);
    end
    rd(0);
`ifdef BP_ME_REG_TIMER_PRESCALE_EN
    check("latched then advanced", {63'd0, (data_o[0] >= exp + 1) && (data_o[0] <= exp + 2)}, 64'd1);
`else
    check("latched then advanced", data_o[0], exp + 6);
`endif

    // Randomized traffic
    drive(0, 4'b0001, 0, 3, 64'd0);
    for (int it = 0; it < 2500; it++) begin
      r = 0; w = 0;
      if ($urandom_range(0, 2) == 0) r = 4'b1 << $urandom_range(0, 3);
      if ($urandom_range(0, 2) == 0) begin
        wi = $urandom_range(0, 3);
        if (wi == 0 && $urandom_range(0, 3) != 0) wi = 3;
        if (!r[wi]) w = 4'b1 << wi;
      end
      rnd = {$urandom, $urandom};
      case (wi)
        0: data = {32'd0, 24'd0, rnd[7:0]};
        1: data = ($urandom_range(0, 3) == 0) ? '1 : {56'd0, rnd[7:0]};
        2: data = {48'd0, rnd[15:8], 6'd0, rnd[1:0]} | 64'h1;
        default: data = rnd;
      endcase
      drive(r, w, rnd[63:24], rnd[1:0], data);
    end

    // Reset mid-operation with strobes active
    drive(0, 4'b0100, 0, 3, 64'h3);
    idle(3);
    reset_n = 0;
    drive(4'b0010, 4'b0001, 0, 3, 64'd123);
    reset_n = 1;
    check("mid reset data_o[1]", data_o[1], 64'd0);
    check("mid reset irq", {63'd0, irq}, 64'd0);
    rd(0);
    check("mid reset mtime", data_o[0], 64'd0);
    rd(1);
    check("mid reset mtimecmp", data_o[1], '1);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
